ram_access_arbiter: RTL

Shares one single-port synchronous RAM (8-bit address, 8-bit data) between `N` requesters using round-robin arbitration, sequencing each read or write through a small FSM. Enforces an address upper bound (`Max`) before any RAM strobe is issued, returning an error instead. Sits between test or bus-side requesters and the `RAM` instance; the `CheckAddr` assertion monitor stays bound to the RAM side.

---
 rtl/ram_access_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between N requesters.
// Defining RAM_ARB_RANGE_CHECK_EN enables the Max address bound check; otherwise Err stays 0.
module ram_access_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic [N-1:0]    Req,
  input  logic [N-1:0]    Wr,
  input  logic [N*AW-1:0] Addr,
  input  logic [N*DW-1:0] WData,
  input  logic [AW-1:0]   Max,
  output logic [N-1:0]    Gnt,
  output logic [N-1:0]    Done,
  output logic [N-1:0]    Err,
  output logic [DW-1:0]   RData,
  output logic [AW-1:0]   RamAddr,
  output logic [DW-1:0]   RamWData,
  output logic            RamWe,
  output logic            RamRe,
  input  logic [DW-1:0]   RamRData
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            wr_q, wr_d;
  logic            fault_q, fault_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [N-1:0]    err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic            ram_we_q, ram_we_d;
  logic            ram_re_q, ram_re_d;

  logic            found;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   pick;
  logic [AW-1:0]   pick_addr;
  logic [DW-1:0]   pick_wdata;
  logic            pick_wr;
  logic            in_range;
  logic [N-1:0]    win_onehot;

  // Scan from the pointer upward; the first active request wins.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    pick  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_q) + k) % N);
      if (!found && Req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_wr    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pick == IW'(k)) begin
        pick_addr  = Addr[k*AW +: AW];
        pick_wdata = WData[k*DW +: DW];
        pick_wr    = Wr[k];
      end
    end
  end

`ifdef RAM_ARB_RANGE_CHECK_EN
  assign in_range = (pick_addr <= Max);
`else
  logic unused_max;
  assign unused_max = ^Max;
  assign in_range   = 1'b1;
`endif

  assign win_onehot = N'(1) << win_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    fault_d     = fault_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StIssue;
          win_d   = pick;
          wr_d    = pick_wr;
          fault_d = !in_range;
          ptr_d   = (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
          gnt_d   = N'(1) << pick;
          // Strobes are registered here so they are visible alongside Gnt in the ISSUE cycle.
          if (in_range) begin
            ram_addr_d = pick_addr;
            if (pick_wr) begin
              ram_wdata_d = pick_wdata;
              ram_we_d    = 1'b1;
            end else begin
              ram_re_d = 1'b1;
            end
          end
        end
      end
      StIssue: begin
        if (wr_q || fault_q) begin
          state_d = StResp;
          done_d  = win_onehot;
          err_d   = fault_q ? win_onehot : '0;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d = StResp;
        rdata_d = RamRData;
        done_d  = win_onehot;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      win_q       <= '0;
      wr_q        <= 1'b0;
      fault_q     <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      fault_q     <= fault_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
    end
  end

  assign Gnt      = gnt_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign RData    = rdata_q;
  assign RamAddr  = ram_addr_q;
  assign RamWData = ram_wdata_q;
  assign RamWe    = ram_we_q;
  assign RamRe    = ram_re_q;

endmodule
